// File: rtl/demux_1a6_reg.sv
// demux_1a6_reg
//   Registered 1-to-6 demultiplexer at the distribution end of the result-select
//   path. One tagged word is accepted per valid/ready transfer. It is steered into
//   one of six per-channel holding registers. Each register has its own
//   valid/ack handshake, so every consumer applies backpressure independently.
//
//   Optional feature macro: DEMUX_BROADCAST_EN
//     Defined   : in_sel=7 loads all six channels when every channel is free.
//     Undefined : in_sel=6 and in_sel=7 are both dropped and counted as errors.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    word to distribute
//   in_sel     destination channel (0..5)
//   in_valid   in_data/in_sel valid
//   in_ready   block can accept this cycle (combinational)
//   out_data   flattened channel registers, channel k at [k*WIDTH +: WIDTH]
//   out_valid  channel k holds an unconsumed word
//   out_ack    consumer k takes its word this cycle
//   err_sel    one-cycle pulse after an invalid select was accepted and dropped
//   err_cnt    saturating count of dropped words

module demux_1a6_reg #(
    parameter int WIDTH = 16,
    parameter int NCH   = 6,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [2:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ack,
    output logic                 err_sel,
    output logic [CNT_W-1:0]     err_cnt
);

    logic [NCH-1:0] chan_free;
    logic [NCH-1:0] load;
    logic           sel_ok;
    logic           accept;
    logic           drop;

    // A full channel being acked this cycle counts as free, so it can be reloaded
    // without a bubble. out_ack reaches in_ready combinationally; it never
    // reaches out_valid except through the register.
    always_comb begin
        chan_free = ~out_valid | out_ack;
        sel_ok    = (in_sel < 3'(NCH));
        in_ready  = 1'b1;
        load      = '0;
        drop      = 1'b0;

        if (sel_ok) begin
            in_ready = chan_free[in_sel];
        end
`ifdef DEMUX_BROADCAST_EN
        else if (in_sel == 3'd7) begin
            in_ready = &chan_free;
        end
`endif

        accept = in_valid & in_ready;

        if (accept) begin
            if (sel_ok) begin
                load[in_sel] = 1'b1;
            end
`ifdef DEMUX_BROADCAST_EN
            else if (in_sel == 3'd7) begin
                load = '1;
            end
`endif
            else begin
                drop = 1'b1;
            end
        end
    end

    // Data is loaded only when its channel is free. Therefore a load either
    // fills an empty channel or replaces a word that is being acked in the same
    // cycle. The data field is left untouched on a plain ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= '0;
            err_sel   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (load[k]) begin
                    out_data[k*WIDTH +: WIDTH] <= in_data;
                end
            end
            out_valid <= (out_valid & ~out_ack) | load;
            err_sel   <= drop;
            if (drop && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux_1a6_reg.sv
module tb_demux_1a6_reg;

    localparam int W  = 16;
    localparam int N  = 6;
    localparam int CW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [W-1:0]   in_data;
    logic [2:0]     in_sel;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ack;
    logic           err_sel;
    logic [CW-1:0]  err_cnt;

    demux_1a6_reg #(.WIDTH(W), .NCH(N), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .err_sel   (err_sel),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]   ch;
        logic [W-1:0] d;
    } sb_t;

    sb_t            sbq[$];
    logic [N-1:0]   m_valid;
    logic [N*W-1:0] m_data;
    logic [CW-1:0]  m_cnt;
    logic           m_err;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transfer cycle: drive the inputs, check in_ready against the
    // reference, advance the reference, and then check the registered outputs
    // after the edge.
    task automatic cyc(input logic v, input logic [2:0] s, input logic [W-1:0] d,
                       input logic [N-1:0] a);
        logic         rdy;
        logic [N-1:0] fr;
        sb_t          e;
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        out_ack  = a;
        #1;
        fr = ~m_valid | a;
        if (s < 3'd6) rdy = fr[s];
        else          rdy = 1'b1;
`ifdef DEMUX_BROADCAST_EN
        if (s == 3'd7) rdy = &fr;
`endif
        chk("in_ready", in_ready, rdy);

        m_valid = m_valid & ~a;
        m_err   = 1'b0;
        if (v && rdy) begin
            if (s < 3'd6) begin
                m_valid[s]       = 1'b1;
                m_data[s*W +: W] = d;
                e.ch = s; e.d = d;
                sbq.push_back(e);
            end
`ifdef DEMUX_BROADCAST_EN
            else if (s == 3'd7) begin
                for (int k = 0; k < N; k++) begin
                    m_valid[k]       = 1'b1;
                    m_data[k*W +: W] = d;
                    e.ch = 3'(k); e.d = d;
                    sbq.push_back(e);
                end
            end
`endif
            else begin
                m_err = 1'b1;
                if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            end
        end

        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_data", out_data[e.ch*W +: W], e.d);
            chk("sb_valid", out_valid[e.ch], 1'b1);
        end
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("err_sel", err_sel, m_err);
        chk("err_cnt", err_cnt, m_cnt);
        in_valid = 1'b0;
        out_ack  = '0;
    endtask

    task automatic model_reset();
        m_valid = '0;
        m_data  = '0;
        m_cnt   = '0;
        m_err   = 1'b0;
        sbq.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 3'd0;
        in_data  = '0;
        out_ack  = '0;
        model_reset();
        #12;
        chk("rst_valid", out_valid, 6'h00);
        chk("rst_data", out_data, '0);
        chk("rst_err_sel", err_sel, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'h00);
        chk("rst_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single load to channel 2.
        cyc(1'b1, 3'd2, 16'hA5A5, 6'h00);
        chk("ch2_only", out_valid, 6'b000100);

        // Channel 3: blocked while full, then reloaded in the same cycle as its ack.
        cyc(1'b1, 3'd3, 16'h5555, 6'h00);
        cyc(1'b1, 3'd3, 16'h1234, 6'h00);
        chk("ch3_held", out_data[3*W +: W], 16'h5555);
        cyc(1'b1, 3'd3, 16'h1234, 6'b001000);
        chk("ch3_reload", out_data[3*W +: W], 16'h1234);

        // Drain, fill all six channels back to back, and then ack them all together.
        cyc(1'b0, 3'd0, 16'h0000, 6'h3F);
        for (int k = 0; k < N; k++) cyc(1'b1, 3'(k), 16'(k + 1), 6'h00);
        chk("all_full", out_valid, 6'h3F);
        cyc(1'b0, 3'd0, 16'h0000, 6'h3F);
        chk("all_acked", out_valid, 6'h00);
        chk("ch5_retained", out_data[5*W +: W], 16'h0006);

        // Invalid selects are dropped.
        cyc(1'b1, 3'd6, 16'hFFFF, 6'h00);
        chk("drop_cnt1", err_cnt, 8'd1);
        cyc(1'b0, 3'd6, 16'hFFFF, 6'h00);
        cyc(1'b1, 3'd7, 16'hBEEF, 6'h00);

`ifdef DEMUX_BROADCAST_EN
        cyc(1'b0, 3'd0, 16'h0000, 6'h3F);
        cyc(1'b1, 3'd7, 16'hBEEF, 6'h00);
        chk("bcast_valid", out_valid, 6'h3F);
        cyc(1'b1, 3'd7, 16'hCAFE, 6'h3E);
        chk("bcast_blocked_ch0", out_data[0*W +: W], 16'hBEEF);
`endif

        // Random traffic with random acks.
        for (int i = 0; i < 200; i++) begin
            cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
                6'($urandom));
        end

        // Error counter saturation.
        for (int i = 0; i < 300; i++) cyc(1'b1, 3'd6, 16'hFFFF, 6'h00);
        chk("err_cnt_sat", err_cnt, 8'hFF);

        // Asynchronous reset while channels 1, 3 and 5 hold words.
        cyc(1'b0, 3'd0, 16'h0000, 6'h3F);
        cyc(1'b1, 3'd1, 16'h1111, 6'h00);
        cyc(1'b1, 3'd3, 16'h3333, 6'h00);
        cyc(1'b1, 3'd5, 16'h5555, 6'h00);
        chk("pre_rst_valid", out_valid, 6'b101010);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_valid", out_valid, 6'h00);
        chk("async_data", out_data, '0);
        chk("async_cnt", err_cnt, 8'h00);
        chk("async_err", err_sel, 1'b0);
        chk("async_ready", in_ready, 1'b1);
        model_reset();
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 3'd4, 16'h4444, 6'h00);
        chk("post_rst_valid", out_valid, 6'b010000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1a6_reg.md
Name: demux_1a6_reg

Overview:
- Registered 1-to-6 demultiplexer. It is the distribution end of the 6-to-1 result-select path.
- Accepts one tagged 16-bit word per transfer over a valid/ready handshake.
- Steers each word into one of six per-channel holding registers, each with its own valid/ack handshake.
- Sits after the logic unit. Routes results to six independent consumers, with per-channel backpressure.

Parameters:
- WIDTH, 16, data width of input word and of each channel register
- NCH, 6, number of output channels (fixed at 6 for 3-bit select; other values unsupported)
- CNT_W, 8, width of saturating error counter

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  word to distribute
- in_sel  input  3  destination channel; 0..5 map to channel 0..5
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  block can accept this cycle
- out_data  output  NCH*WIDTH  flattened channel registers; channel k at bits [k*WIDTH +: WIDTH]
- out_valid  output  NCH  channel k holds an unconsumed word
- out_ack  input  NCH  consumer k takes word this cycle
- err_sel  output  1  one-cycle pulse: invalid select accepted and dropped
- err_cnt  output  CNT_W  saturating count of dropped words

Behaviour:
- Reset (async, rst_n=0): out_data=0, out_valid=0, err_sel=0, err_cnt=0. in_ready is combinational; it reads 1 during reset once channels clear.
- Channel k free = !out_valid[k] | out_ack[k]. A full channel can be reloaded in the same cycle it is acked.
- in_ready (combinational):
  - in_sel in 0..5: equals free(in_sel).
  - in_sel 6 or 7: 1 (drop path).
- Accept = in_valid & in_ready.
- Accept with sel k (0..5), next edge: out_data[k] <= in_data, out_valid[k] <= 1. Latency is 1 cycle from accept to out_valid.
- Ack on channel k without a simultaneous load: out_valid[k] <= 0. out_data[k] holds its last value; it is not cleared.
- Simultaneous ack and load on the same channel: out_valid stays 1 and the new data is loaded. No bubble.
- out_ack[k] while out_valid[k]=0: ignored.
- Multiple acks in one cycle: each channel is independent. Only one channel can load per cycle.
- Stability: out_data[k] must not change while out_valid[k]=1 and out_ack[k]=0.
- Invalid sel (6/7) accepted:
  - No channel changes.
  - err_sel=1 for exactly the next cycle.
  - err_cnt increments, saturating at 2^CNT_W-1 with no wrap.
- in_valid=0: in_sel and in_data are don't-care. No state change apart from acks.
- Reset asserted mid-transfer: all pending words are discarded immediately. On release, the block starts empty.
- No combinational path from out_ack to out_valid. The path from out_ack to in_ready is permitted.

Optional Feature:
- Macro: DEMUX_BROADCAST_EN.
- Defined:
  - in_sel=7 is broadcast. in_ready = AND of free(k) over all 6 channels.
  - On accept, all six channels load in_data and set out_valid on the next edge. No err_sel, no err_cnt change.
  - Only in_sel=6 is invalid/dropped.
- Undefined: 6 and 7 are both invalid, as above.

Test Plan:
- Reset then in_valid=1, sel=2, data=16'hA5A5 -> in_ready=1; next cycle out_valid=6'b000100, channel 2 data=A5A5, other channels 0.
- Channel 3 held full (no ack), second word sel=3 data=16'h1234 -> in_ready=0, channel 3 keeps old data. Assert out_ack[3] same cycle -> accept; next cycle channel 3=1234, out_valid[3] still 1.
- Load all six channels with 16'h0001..16'h0006 in consecutive cycles, ack all at once -> out_valid goes 3F->00 in one cycle; data retained.
- sel=6 data=16'hFFFF -> in_ready=1, err_sel pulses 1 cycle, err_cnt=1, out_valid unchanged.
- Feed 300 words with sel=6 -> err_cnt saturates at 255.
- Assert rst_n=0 with out_valid=6'b101010 -> all outputs 0 asynchronously, before the next clk edge.
- With DEMUX_BROADCAST_EN: sel=7 data=16'hBEEF, all channels empty -> next cycle out_valid=3F, all channels BEEF. Repeat with channel 0 full and un-acked -> in_ready=0.
